fpga_mbox_sram_arb: RTL and testbench
=====================================

// Module: fpga_mbox_sram_arb
//
// PURPOSE
// Shares the single-port mailbox SRAM on the FPGA wrapper between the Caliptra
// mailbox port (fixed 1-cycle-latency, no backpressure) and an FPGA-side debug
// requester (valid/ready). After reset it zero-sweeps the SRAM, then arbitrates
// with Caliptra at absolute priority. Sits between caliptra_top mbox_sram_* and fpga_mbox_ram.
//
// PARAMETERS
// ADDR_W        15    SRAM word-address width
// DATA_W        39    data+ECC width (MBOX_DATA_AND_ECC_W)
// DEPTH         32768 words swept during INIT (<= 2**ADDR_W)
// STARVE_LIMIT  256   debug wait cycles before starve asserts; saturating counter
//
// PORTS
// core_clk       in   1       clock for all logic and SRAM
// rst            in   1       async, active-high reset
// cptra_cs       in   1       Caliptra SRAM select
// cptra_we       in   1       Caliptra write enable
// cptra_addr     in   ADDR_W  Caliptra address
// cptra_wdata    in   DATA_W  Caliptra write data
// cptra_rdata    out  DATA_W  Caliptra read data (valid cycle after read cs)
// dbg_req_valid  in   1       debug request valid
// dbg_req_ready  out  1       debug request accepted this cycle
// dbg_req_we     in   1       debug write(1)/read(0)
// dbg_req_addr   in   ADDR_W  debug address
// dbg_req_wdata  in   DATA_W  debug write data
// dbg_rsp_valid  out  1       debug read data valid (1-cycle pulse)
// dbg_rsp_rdata  out  DATA_W  debug read data
// sram_cs/we     out  1 each  SRAM select / write enable
// sram_addr      out  ADDR_W  SRAM address
// sram_wdata     out  DATA_W  SRAM write data
// sram_rdata     in   DATA_W  SRAM read data, 1-cycle latency
// init_done      out  1       zero-sweep complete; Caliptra may be released
// init_collision out  1       sticky: cptra_cs seen during INIT
// starve         out  1       debug waited STARVE_LIMIT cycles
//
// BEHAVIOUR
// - Reset values: all outputs 0; state=INIT; sweep_addr=0; starve_cnt=0.
// - INIT: each cycle sram_cs=1, sram_we=1, sram_wdata=0, sram_addr=sweep_addr;
//   sweep_addr++. After writing DEPTH-1, next cycle state=ARB, init_done=1
//   (stays 1 until reset). INIT lasts exactly DEPTH cycles.
// - In INIT: dbg_req_ready=0; cptra_cs not forwarded, sets init_collision (sticky).
// - ARB: cptra_cs=1 -> SRAM driven combinationally from cptra_*; dbg_req_ready=0.
//   cptra_cs=0 -> dbg_req_ready=1; if dbg_req_valid, SRAM driven from dbg_req_*.
//   Simultaneous requests: Caliptra always wins, debug holds its request stable.
// - cptra_rdata = sram_rdata combinationally (Caliptra ignores it unless it read).
// - dbg read accepted in cycle N -> dbg_rsp_valid=1 in N+1 only, dbg_rsp_rdata =
//   sram_rdata that cycle; 0 otherwise. Debug writes produce no response.
//   Back-to-back debug reads: one response per cycle, in order.
// - starve_cnt: +1 each ARB cycle with dbg_req_valid && !dbg_req_ready,
//   saturates at STARVE_LIMIT; cleared on debug accept. starve = (cnt==STARVE_LIMIT).
// - Reset asserted mid-INIT or mid-read: immediate return to reset values; pending
//   dbg response is dropped (no dbg_rsp_valid after reset); sweep restarts at 0.
//
// TESTING
// - DEPTH=16: release rst -> 16 zero writes addr 0..15, init_done=1 at cycle 16.
// - cptra_cs=1 at INIT cycle 3 -> not on sram_cs, init_collision=1 and stays 1.
// - ARB: dbg write 0x12 @5, dbg read @5 -> dbg_rsp_valid next cycle, rdata=0x12.
// - cptra_cs and dbg_req_valid same cycle -> sram_addr=cptra_addr, ready=0;
//   cptra idle next cycle -> debug accepted, starve_cnt cleared.
// - STARVE_LIMIT=4, cptra_cs held 1 with dbg valid -> starve=1 after 4 cycles.
// - rst pulsed the cycle after a dbg read accept -> no dbg_rsp_valid; INIT restarts at addr 0.

Source files
------------

// File: rtl/fpga_mbox_sram_arb.sv
// Mailbox SRAM arbiter: zero-sweeps DEPTH words after reset, then shares the port with Caliptra at absolute priority.
// SRAM drive is combinational; debug reads respond one cycle after accept; debug stalls whenever Caliptra selects.
module fpga_mbox_sram_arb #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 39,
  parameter int DEPTH        = 32768,
  parameter int STARVE_LIMIT = 256
) (
  input  logic              core_clk,
  input  logic              rst,
  input  logic              cptra_cs,
  input  logic              cptra_we,
  input  logic [ADDR_W-1:0] cptra_addr,
  input  logic [DATA_W-1:0] cptra_wdata,
  output logic [DATA_W-1:0] cptra_rdata,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done,
  output logic              init_collision,
  output logic              starve
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STARVE_LIMIT);

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
  logic              collision_q, collision_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rsp_pend_q, rsp_pend_d;

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      sweep_addr_q <= '0;
      collision_q  <= 1'b0;
      starve_cnt_q <= '0;
      rsp_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      collision_q  <= collision_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_addr_d  = sweep_addr_q;
    collision_d   = collision_q;
    starve_cnt_d  = starve_cnt_q;
    rsp_pend_d    = 1'b0;
    sram_cs       = 1'b0;
    sram_we       = 1'b0;
    sram_addr     = '0;
    sram_wdata    = '0;
    dbg_req_ready = 1'b0;

    case (state_q)
      S_INIT: begin
        sram_cs      = 1'b1;
        sram_we      = 1'b1;
        sram_addr    = sweep_addr_q;
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (sweep_addr_q == LAST_ADDR) begin
          state_d      = S_ARB;
          sweep_addr_d = '0;
        end
        // Caliptra should still be held off here; flag it rather than corrupt the sweep.
        if (cptra_cs) collision_d = 1'b1;
      end
      S_ARB: begin
        if (cptra_cs) begin
          sram_cs    = 1'b1;
          sram_we    = cptra_we;
          sram_addr  = cptra_addr;
          sram_wdata = cptra_wdata;
        end else begin
          dbg_req_ready = 1'b1;
          if (dbg_req_valid) begin
            sram_cs    = 1'b1;
            sram_we    = dbg_req_we;
            sram_addr  = dbg_req_addr;
            sram_wdata = dbg_req_wdata;
            rsp_pend_d = !dbg_req_we;
          end
        end
        if (dbg_req_valid && !dbg_req_ready) begin
          if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (dbg_req_valid) begin
          starve_cnt_d = '0;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Keep every output quiet while reset is held.
    if (rst) begin
      sram_cs       = 1'b0;
      sram_we       = 1'b0;
      sram_addr     = '0;
      sram_wdata    = '0;
      dbg_req_ready = 1'b0;
    end
  end

  assign cptra_rdata    = rst ? '0 : sram_rdata;
  assign dbg_rsp_valid  = rsp_pend_q;
  assign dbg_rsp_rdata  = rsp_pend_q ? sram_rdata : '0;
  assign init_done      = (state_q == S_ARB);
  assign init_collision = collision_q;
  assign starve         = (starve_cnt_q == LIMIT);

endmodule

// File: tb/tb_fpga_mbox_sram_arb.sv
// Directed bench for fpga_mbox_sram_arb with a small behavioural SRAM (DEPTH=16, STARVE_LIMIT=4).
module tb_fpga_mbox_sram_arb;
  localparam int AW = 15;
  localparam int DW = 39;

  logic          core_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cptra_cs = 1'b0, cptra_we = 1'b0;
  logic [AW-1:0] cptra_addr = '0;
  logic [DW-1:0] cptra_wdata = '0;
  logic [DW-1:0] cptra_rdata;
  logic          dbg_req_valid = 1'b0, dbg_req_ready, dbg_req_we = 1'b0;
  logic [AW-1:0] dbg_req_addr = '0;
  logic [DW-1:0] dbg_req_wdata = '0;
  logic          dbg_rsp_valid;
  logic [DW-1:0] dbg_rsp_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          init_done, init_collision, starve;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [0:31];

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr[4:0]] <= sram_wdata;
      else sram_rdata <= mem[sram_addr[4:0]];
    end
  end

  fpga_mbox_sram_arb #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .STARVE_LIMIT(4)) dut (
    .core_clk(core_clk), .rst(rst),
    .cptra_cs(cptra_cs), .cptra_we(cptra_we), .cptra_addr(cptra_addr),
    .cptra_wdata(cptra_wdata), .cptra_rdata(cptra_rdata),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done), .init_collision(init_collision), .starve(starve)
  );

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mem[i] = 39'h5A5A5A5A5A;
    rst = 1'b1;
    repeat (2) @(negedge core_clk);
    #1;
    vectors++;
    if ({sram_cs, sram_we, init_done, init_collision, starve, dbg_req_ready, dbg_rsp_valid} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000000",
               {sram_cs, sram_we, init_done, init_collision, starve, dbg_req_ready, dbg_rsp_valid});
    end
    vectors++;
    if (sram_addr !== '0 || cptra_rdata !== '0 || dbg_rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_buses got addr=%h crd=%h drd=%h want 0", sram_addr, cptra_rdata, dbg_rsp_rdata);
    end
  endtask

  task automatic test_init_sweep();
    @(negedge core_clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cptra_cs      = (i == 3);
      dbg_req_valid = (i >= 5 && i <= 14);
      #1;
      vectors++;
      if (sram_cs !== 1'b1 || sram_we !== 1'b1 || sram_wdata !== '0 || sram_addr !== AW'(i)) begin
        miscompares++;
        $display("FAIL init_write[%0d] got cs=%b we=%b addr=%0d wd=%h want cs=1 we=1 addr=%0d wd=0",
                 i, sram_cs, sram_we, sram_addr, sram_wdata, i);
      end
      vectors++;
      if (init_done !== 1'b0 || dbg_req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL init_idle[%0d] got done=%b rdy=%b want 0 0", i, init_done, dbg_req_ready);
      end
      vectors++;
      if (init_collision !== (i >= 4)) begin
        miscompares++;
        $display("FAIL init_collision[%0d] got %b want %b", i, init_collision, (i >= 4));
      end
      @(negedge core_clk);
    end
    cptra_cs = 1'b0;
    #1;
    vectors++;
    if (init_done !== 1'b1 || init_collision !== 1'b1 || starve !== 1'b0) begin
      miscompares++;
      $display("FAIL init_end got done=%b coll=%b starve=%b want 1 1 0", init_done, init_collision, starve);
    end
    vectors++;
    if (mem[0] !== '0 || mem[7] !== '0 || mem[15] !== '0 || mem[16] !== 39'h5A5A5A5A5A) begin
      miscompares++;
      $display("FAIL init_mem got m0=%h m7=%h m15=%h m16=%h want 0 0 0 5a5a5a5a5a",
               mem[0], mem[7], mem[15], mem[16]);
    end
  endtask

  task automatic test_dbg_rw();
    @(negedge core_clk);
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5; dbg_req_wdata = 39'h12;
    #1;
    vectors++;
    if (dbg_req_ready !== 1'b1 || sram_cs !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(5) || sram_wdata !== 39'h12) begin
      miscompares++;
      $display("FAIL dbg_write got rdy=%b cs=%b we=%b addr=%0d wd=%h want 1 1 1 5 12",
               dbg_req_ready, sram_cs, sram_we, sram_addr, sram_wdata);
    end
    @(negedge core_clk);
    dbg_req_we = 1'b0;
    #1;
    vectors++;
    if (dbg_rsp_valid !== 1'b0 || sram_we !== 1'b0 || sram_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL dbg_read_issue got rspv=%b we=%b cs=%b want 0 0 1", dbg_rsp_valid, sram_we, sram_cs);
    end
    @(negedge core_clk);
    dbg_req_valid = 1'b0;
    #1;
    vectors++;
    if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== 39'h12) begin
      miscompares++;
      $display("FAIL dbg_read_rsp got v=%b d=%h want 1 12", dbg_rsp_valid, dbg_rsp_rdata);
    end
    @(negedge core_clk);
    #1;
    vectors++;
    if (dbg_rsp_valid !== 1'b0 || dbg_rsp_rdata !== '0 || sram_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL dbg_rsp_pulse got v=%b d=%h cs=%b want 0 0 0", dbg_rsp_valid, dbg_rsp_rdata, sram_cs);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [5];
    logic [DW-1:0] exp   [3];
    addrs = '{AW'(6), AW'(7), AW'(5), AW'(6), AW'(7)};
    exp   = '{39'h12, 39'h7F_FFFF_FFFF, 39'h0B_B000_00BB};
    @(negedge core_clk);
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = addrs[0]; dbg_req_wdata = exp[1];
    @(negedge core_clk);
    dbg_req_addr = addrs[1]; dbg_req_wdata = exp[2];
    for (int k = 2; k < 6; k++) begin
      @(negedge core_clk);
      if (k < 5) begin
        dbg_req_we = 1'b0; dbg_req_addr = addrs[k];
      end else begin
        dbg_req_valid = 1'b0;
      end
      #1;
      vectors++;
      if (k == 2) begin
        if (dbg_rsp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_no_wr_rsp got %b want 0", dbg_rsp_valid);
        end
      end else if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== exp[k-3]) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d] got v=%b d=%h want 1 %h", k - 3, dbg_rsp_valid, dbg_rsp_rdata, exp[k-3]);
      end
    end
    vectors++;
    if (cptra_rdata !== exp[2]) begin
      miscompares++;
      $display("FAIL cptra_rdata_passthru got %h want %h", cptra_rdata, exp[2]);
    end
  endtask

  task automatic test_priority();
    @(negedge core_clk);
    cptra_cs = 1'b1; cptra_we = 1'b0; cptra_addr = 7;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 6;
    #1;
    vectors++;
    if (sram_addr !== AW'(7) || dbg_req_ready !== 1'b0 || sram_we !== 1'b0 || sram_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_cptra got addr=%0d rdy=%b we=%b cs=%b want 7 0 0 1", sram_addr, dbg_req_ready, sram_we, sram_cs);
    end
    @(negedge core_clk);
    cptra_cs = 1'b0;
    #1;
    vectors++;
    if (dbg_req_ready !== 1'b1 || sram_addr !== AW'(6) || cptra_rdata !== 39'h0B_B000_00BB || dbg_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_dbg got rdy=%b addr=%0d crd=%h rspv=%b want 1 6 0bb00000bb 0",
               dbg_req_ready, sram_addr, cptra_rdata, dbg_rsp_valid);
    end
    @(negedge core_clk);
    dbg_req_valid = 1'b0;
    #1;
    vectors++;
    if (dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== 39'h7F_FFFF_FFFF || starve !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_rsp got v=%b d=%h starve=%b want 1 7fffffffff 0", dbg_rsp_valid, dbg_rsp_rdata, starve);
    end
  endtask

  task automatic test_starve();
    @(negedge core_clk);
    cptra_cs = 1'b1; cptra_we = 1'b0; cptra_addr = 0;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5;
    for (int n = 0; n < 7; n++) begin
      #1;
      vectors++;
      if (starve !== (n >= 4)) begin
        miscompares++;
        $display("FAIL starve[%0d] got %b want %b", n, starve, (n >= 4));
      end
      @(negedge core_clk);
    end
    cptra_cs = 1'b0;
    #1;
    vectors++;
    if (dbg_req_ready !== 1'b1 || starve !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_accept got rdy=%b starve=%b want 1 1", dbg_req_ready, starve);
    end
    @(negedge core_clk);
    dbg_req_valid = 1'b0;
    #1;
    vectors++;
    if (starve !== 1'b0 || dbg_rsp_valid !== 1'b1 || dbg_rsp_rdata !== 39'h12) begin
      miscompares++;
      $display("FAIL starve_clear got starve=%b v=%b d=%h want 0 1 12", starve, dbg_rsp_valid, dbg_rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge core_clk);
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5;
    @(negedge core_clk);
    dbg_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (dbg_rsp_valid !== 1'b0 || dbg_rsp_rdata !== '0 || init_done !== 1'b0 || init_collision !== 1'b0 || sram_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_read got v=%b d=%h done=%b coll=%b cs=%b want 0 0 0 0 0",
               dbg_rsp_valid, dbg_rsp_rdata, init_done, init_collision, sram_cs);
    end
    @(negedge core_clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (dbg_rsp_valid !== 1'b0 || sram_cs !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(i) || init_done !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_restart[%0d] got v=%b cs=%b we=%b addr=%0d done=%b want 0 1 1 %0d 0",
                 i, dbg_rsp_valid, sram_cs, sram_we, sram_addr, init_done, i);
      end
      @(negedge core_clk);
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_dbg_rw();
    test_back_to_back();
    test_priority();
    test_starve();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
